// File: rtl/cmos_pattern_gen_if.sv
// Parallel CMOS camera video bus: frame sync, line-valid strobe and data beat.
// The generator drives it through the master modport; a sink uses the slave modport.
interface cmos_pattern_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  cmos_vsync;
    logic                  cmos_href;
    logic [DATA_WIDTH-1:0] cmos_data;

    modport master (output cmos_vsync, output cmos_href, output cmos_data);
    modport slave  (input  cmos_vsync, input  cmos_href, input  cmos_data);
endinterface

// File: rtl/cmos_pattern_gen.sv
// CMOS sensor timing/pattern generator (ramp, checker, constant, optional LFSR noise).
// Define CMOS_PATTERN_NOISE_EN to compile in the noise pattern; otherwise mode 3 gives the ramp.
module cmos_pattern_gen #(
    parameter int   DATA_WIDTH  = 8,
    parameter int   IMG_HDISP   = 640,
    parameter int   BPP         = 2,
    parameter int   IMG_VDISP   = 480,
    parameter int   H_BLANK     = 160,
    parameter int   VSYNC_LINES = 3,
    parameter int   V_BACK      = 17,
    parameter int   V_FRONT     = 10,
    parameter logic VSYNC_VALID = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [1:0]            pattern_mode,
    input  logic [DATA_WIDTH-1:0] const_value,
    cmos_pattern_gen_if.master    video,
    output logic [15:0]           frame_cnt
);
    localparam int H_ACT   = IMG_HDISP * BPP;
    localparam int H_TOTAL = H_ACT + H_BLANK;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int L_MAX_A = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int L_MAX_B = (IMG_VDISP > V_FRONT) ? IMG_VDISP : V_FRONT;
    localparam int L_MAX   = (L_MAX_A > L_MAX_B) ? L_MAX_A : L_MAX_B;
    localparam int LW      = (L_MAX > 1) ? $clog2(L_MAX) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_W  = HW'(H_ACT);
    localparam logic [LW-1:0] VS_LAST  = LW'(VSYNC_LINES - 1);
    localparam logic [LW-1:0] VB_LAST  = LW'(V_BACK - 1);
    localparam logic [LW-1:0] VA_LAST  = LW'(IMG_VDISP - 1);
    localparam logic [LW-1:0] VF_LAST  = LW'(V_FRONT - 1);

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

    state_t                state_reg, state_next;
    logic [HW-1:0]         h_reg, h_next;
    logic [LW-1:0]         line_reg, line_next;
    logic [LW-1:0]         line_last;
    logic                  frame_done;
    logic                  vsync_entry;
    logic                  href_next;
    logic                  chk_next;
    logic [DATA_WIDTH-1:0] ramp_next;
    logic [DATA_WIDTH-1:0] data_next;
    logic [1:0]            mode_reg;
    logic [DATA_WIDTH-1:0] const_reg;

`ifdef CMOS_PATTERN_NOISE_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    logic [15:0] lfsr_reg, lfsr_next;
`endif

    // Line/state sequencing: every non-idle state runs whole lines of H_TOTAL cycles.
    always_comb begin
        state_next = state_reg;
        h_next     = h_reg;
        line_next  = line_reg;
        frame_done = 1'b0;
        case (state_reg)
            VSYNC:   line_last = VS_LAST;
            VBACK:   line_last = VB_LAST;
            ACTIVE:  line_last = VA_LAST;
            VFRONT:  line_last = VF_LAST;
            default: line_last = '0;
        endcase
        if (state_reg == IDLE) begin
            h_next    = '0;
            line_next = '0;
            if (enable) state_next = VSYNC;
        end else if (h_reg != H_LAST) begin
            h_next = h_reg + 1'b1;
        end else begin
            h_next = '0;
            if (line_reg != line_last) begin
                line_next = line_reg + 1'b1;
            end else begin
                line_next = '0;
                case (state_reg)
                    VSYNC:   state_next = VBACK;
                    VBACK:   state_next = ACTIVE;
                    ACTIVE:  state_next = VFRONT;
                    default: begin
                        frame_done = 1'b1;
                        state_next = enable ? VSYNC : IDLE;
                    end
                endcase
            end
        end
    end

    // Outputs are derived from the next state/counters so they change together with them.
    always_comb begin
        vsync_entry = (state_next == VSYNC) && (state_reg != VSYNC);
        href_next   = (state_next == ACTIVE) && (h_next < H_ACT_W);
        chk_next    = (((32'(h_next) / 32'(BPP)) & 32'd8) != 32'd0) ^
                      ((32'(line_next) & 32'd8) != 32'd0);
        ramp_next   = DATA_WIDTH'(32'(h_next) + 32'(line_next));
        data_next   = '0;
        if (href_next) begin
            case (mode_reg)
                2'd1:    data_next = {DATA_WIDTH{chk_next}};
                2'd2:    data_next = const_reg;
`ifdef CMOS_PATTERN_NOISE_EN
                2'd3:    data_next = DATA_WIDTH'(lfsr_reg);
`endif
                default: data_next = ramp_next;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            h_reg            <= '0;
            line_reg         <= '0;
            mode_reg         <= '0;
            const_reg        <= '0;
            frame_cnt        <= '0;
            video.cmos_vsync <= ~VSYNC_VALID;
            video.cmos_href  <= 1'b0;
            video.cmos_data  <= '0;
        end else begin
            state_reg <= state_next;
            h_reg     <= h_next;
            line_reg  <= line_next;
            if (vsync_entry) begin
                mode_reg  <= pattern_mode;
                const_reg <= const_value;
            end
            if (frame_done) frame_cnt <= frame_cnt + 16'd1;
            video.cmos_vsync <= (state_next == VSYNC) ? VSYNC_VALID : ~VSYNC_VALID;
            video.cmos_href  <= href_next;
            video.cmos_data  <= data_next;
        end
    end

`ifdef CMOS_PATTERN_NOISE_EN
    // Galois form of x^16+x^14+x^13+x^11+1, stepping once per emitted beat.
    always_comb begin
        lfsr_next = lfsr_reg;
        if (vsync_entry) lfsr_next = LFSR_SEED;
        else if (href_next) lfsr_next = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ 16'hB400) : (lfsr_reg >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_reg <= LFSR_SEED;
        else        lfsr_reg <= lfsr_next;
    end
`endif
endmodule

// File: doc/cmos_pattern_gen.md
CMOS_PATTERN_GEN -- requirements
Module: cmos_pattern_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per data beat.
REQ-002 SHALL have parameter IMG_HDISP, default 640, active pixels per line.
REQ-003 SHALL have parameter BPP, default 2, data beats per pixel (1..2).
REQ-004 SHALL have parameter IMG_VDISP, default 480, active lines per frame.
REQ-005 SHALL have parameter H_BLANK, default 160, blanking cycles per line (>=1).
REQ-006 SHALL have parameters VSYNC_LINES, V_BACK, V_FRONT, defaults 3, 17, 10, line counts (each >=1).
REQ-007 SHALL have parameter VSYNC_VALID, default 1'b1, active level of cmos_vsync.
REQ-008 clk  input  1  pixel clock; all logic on its rising edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 enable  input  1  high: generate frames continuously; low: stop after current frame.
REQ-011 pattern_mode  input  2  0 ramp, 1 checker, 2 constant, 3 noise.
REQ-012 const_value  input  DATA_WIDTH  value for constant pattern.
REQ-013 cmos_vsync  output  1  frame sync, VSYNC_VALID during sync lines.
REQ-014 cmos_href  output  1  high on valid data beats.
REQ-015 cmos_data  output  DATA_WIDTH  pixel data beat.
REQ-016 frame_cnt  output  16  completed-frame count, wraps 16'hFFFF->0.

Function
REQ-017 SHALL use states IDLE, VSYNC, VBACK, ACTIVE, VFRONT; all outputs registered, updated in the same cycle as state/counters.
REQ-018 SHALL define H_TOTAL = IMG_HDISP*BPP + H_BLANK; h_cnt counts 0..H_TOTAL-1 in every non-IDLE state, one line per wrap.
REQ-019 IDLE->VSYNC the cycle after enable is sampled high; h_cnt=0, line count=0 on entry.
REQ-020 VSYNC->VBACK after VSYNC_LINES lines, VBACK->ACTIVE after V_BACK lines, ACTIVE->VFRONT after IMG_VDISP lines.
REQ-021 At end of VFRONT's V_FRONT lines: frame_cnt increments; next state VSYNC if enable high, else IDLE.
REQ-022 enable deassertion mid-frame SHALL NOT truncate the frame.
REQ-023 cmos_vsync SHALL equal VSYNC_VALID exactly while in VSYNC, else ~VSYNC_VALID.
REQ-024 cmos_href SHALL be high iff state ACTIVE and h_cnt < IMG_HDISP*BPP.
REQ-025 cmos_data SHALL be 0 whenever cmos_href is low.
REQ-026 pattern_mode and const_value SHALL be latched on entry to VSYNC; changes mid-frame ignored.
REQ-027 Ramp: data = (h_cnt + active line index) mod 2^DATA_WIDTH.
REQ-028 Checker: pixel x = h_cnt/BPP, line y; data all-ones if (x[3] XOR y[3]) else all-zeros (8x8 blocks).
REQ-029 Constant: data = latched const_value.
REQ-030 Noise: 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1, seeded 16'hACE1 on VSYNC entry, advanced once per href beat, data = low DATA_WIDTH bits of LFSR before advance (zero-extended if DATA_WIDTH>16).

Reset
REQ-031 On rst_n low: state IDLE, counters 0, LFSR 16'hACE1, latched mode 0, cmos_vsync=~VSYNC_VALID, cmos_href=0, cmos_data=0, frame_cnt=0.
REQ-032 Reset mid-frame SHALL abort immediately; after release a new frame starts from VSYNC per REQ-019.

Configuration
REQ-033 Macro CMOS_PATTERN_NOISE_EN defined: noise mode per REQ-030 compiled in.
REQ-034 Macro undefined: no LFSR logic; pattern_mode 3 SHALL behave as ramp.

Verification
Bench params: IMG_HDISP=4, BPP=2, IMG_VDISP=2, H_BLANK=2, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, so H_TOTAL=10, frame=50 cycles.
REQ-035 enable=1, mode 0 -> vsync high 10 cycles, 10 idle, href 8 cycles data 0..7, 2 low, href data 1..8, 10 front cycles; frame_cnt=1 at cycle 50.
REQ-036 mode 2, const_value=8'h5A, mode switched to 0 mid-frame -> all 16 href beats 8'h5A; next frame ramp.
REQ-037 enable dropped at cycle 15 of frame -> full 50-cycle frame completes, frame_cnt increments, state IDLE, vsync stays inactive.
REQ-038 rst_n pulsed low during ACTIVE with enable=1 -> all outputs reset values same cycle asynchronously; new frame vsync starts one cycle after release; frame_cnt=0.
REQ-039 mode 3 with CMOS_PATTERN_NOISE_EN -> first beat 8'hE1, sequence identical across frames; without macro -> ramp 0..7.
REQ-040 frame_cnt forced past 16'hFFFF over 65536 frames (or VSYNC_VALID=0 build) -> wraps to 0; vsync active-low polarity correct.
